// File: rtl/filt_sched.sv
// Sequencer for the folded 512-tap 1-bit FIR: it gates delay-line shifts, tracks fill and decimation phase,
// and walks the folded taps with MAC/round strobes into a valid/ready output register.
module filt_sched #(
    parameter int unsigned NTAPS = 512,
    parameter int unsigned HALF  = 256,
    parameter int unsigned DECIM = 384,
    parameter int unsigned OW    = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          bit_valid_i,
    output logic          shift_en_o,
    output logic          snap_o,
    output logic          acc_clr_o,
    output logic          mac_en_o,
    output logic [7:0]    tap_idx_o,
    output logic          round_en_o,
    input  logic [OW-1:0] dp_result_i,
    output logic [OW-1:0] dout_o,
    output logic          dout_valid_o,
    input  logic          dout_ready_i,
    output logic          busy_o,
    output logic          overrun_o
);

    localparam int unsigned PW = $clog2(DECIM);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_WAIT, S_SNAP, S_CALC, S_ROUND, S_CAPT
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    fill_q, fill_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    tap_q, tap_d;
    logic [OW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic accept, free, due, busy;

    assign accept = bit_valid_i & enable_i;
    assign free   = ~valid_q | dout_ready_i;
    assign busy   = (state_q == S_SNAP) || (state_q == S_CALC) ||
                    (state_q == S_ROUND) || (state_q == S_CAPT);

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        phase_d    = phase_q;
        tap_d      = tap_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        due        = 1'b0;
        snap_o     = 1'b0;
        acc_clr_o  = 1'b0;
        mac_en_o   = 1'b0;
        round_en_o = 1'b0;

        if (valid_q && dout_ready_i) valid_d = 1'b0;

        // The decimation phase keeps running through the busy states so a late snapshot is detectable.
        if (accept && (state_q != S_IDLE) && (state_q != S_FILL)) begin
            if (phase_q == PW'(DECIM - 1)) begin
                due     = 1'b1;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_FILL;
                    fill_d  = accept ? 10'd1 : 10'd0;
                    phase_d = '0;
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (fill_q == 10'(NTAPS - 1)) begin
                        due     = 1'b1;
                        phase_d = '0;
                        state_d = S_WAIT;
                    end else begin
                        fill_d = fill_q + 10'd1;
                    end
                end
            end
            S_WAIT: ;
            S_SNAP: begin
                snap_o    = 1'b1;
                acc_clr_o = 1'b1;
                tap_d     = '0;
                state_d   = S_CALC;
            end
            S_CALC: begin
                mac_en_o = 1'b1;
                tap_d    = tap_q + 8'd1;
                if (tap_q == 8'(HALF - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                round_en_o = 1'b1;
                state_d    = S_CAPT;
            end
            S_CAPT: begin
                dout_d  = dp_result_i;
                valid_d = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase

        if (due) begin
            if (busy || !free) ovr_d = 1'b1;
            else               state_d = S_SNAP;
        end

        if (!enable_i) begin
            state_d = S_IDLE;
            fill_d  = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
            phase_q <= '0;
            tap_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            phase_q <= phase_d;
            tap_q   <= tap_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign shift_en_o   = accept;
    assign tap_idx_o    = (state_q == S_CALC) ? tap_q : '0;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign busy_o       = busy;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_filt_sched.sv
// Bench for filt_sched: directed scenarios plus random traffic, every cycle compared with a timeline
// model built from accepted-bit counts and snapshot times.
module tb_filt_sched;

    localparam int NT = 512;
    localparam int HF = 256;
    localparam int DC = 384;

    logic        clk = 1'b0;
    logic        rst, en, bv, rdy;
    logic [15:0] dp;
    logic        shift_en, snap, acc_clr, mac_en, round_en, dout_valid, busy, overrun;
    logic [7:0]  tap_idx;
    logic [15:0] dout;

    always #5 clk = ~clk;

    filt_sched #(.NTAPS(NT), .HALF(HF), .DECIM(DC), .OW(16)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .bit_valid_i(bv),
        .shift_en_o(shift_en), .snap_o(snap), .acc_clr_o(acc_clr), .mac_en_o(mac_en),
        .tap_idx_o(tap_idx), .round_en_o(round_en), .dp_result_i(dp), .dout_o(dout),
        .dout_valid_o(dout_valid), .dout_ready_i(rdy), .busy_o(busy), .overrun_o(overrun)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Model: nacc = accepts in the current enable run; a job is a snapshot at cycle job_s.
    longint      cyc;
    int          nacc;
    bit          job_on;
    longint      job_s;
    bit          m_valid;
    logic [15:0] m_dout;
    bit          m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        nacc = 0; job_on = 0; job_s = 0; m_valid = 0; m_dout = '0; m_ovr = 0;
    endtask

    task automatic step();
        bit     in_job, cap, acc, due, free;
        longint k;
        @(negedge clk);
        in_job = job_on && (cyc >= job_s) && (cyc <= job_s + HF + 2);
        k      = cyc - job_s;
        cap    = in_job && (k == HF + 2);
        check("shift_en",   shift_en,   bv & en);
        check("snap",       snap,       in_job && k == 0);
        check("acc_clr",    acc_clr,    in_job && k == 0);
        check("mac_en",     mac_en,     in_job && k >= 1 && k <= HF);
        check("tap_idx",    tap_idx,    (in_job && k >= 1 && k <= HF) ? 32'(k - 1) : 32'd0);
        check("round_en",   round_en,   in_job && k == HF + 1);
        check("busy",       busy,       in_job);
        check("dout_valid", dout_valid, m_valid);
        check("dout",       dout,       m_dout);
        check("overrun",    overrun,    m_ovr);

        if (rst) begin
            model_clear();
        end else begin
            free = !m_valid || rdy;
            acc  = bv && en;
            due  = 0;
            if (cap) begin
                m_valid = 1; m_dout = dp; job_on = 0;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (!en) begin
                nacc = 0;
                if (in_job && !cap) job_on = 0;
            end else if (acc) begin
                nacc++;
                due = (nacc == NT) || (nacc > NT && ((nacc - NT) % DC) == 0);
            end
            if (due) begin
                if (in_job || !free) m_ovr = 1;
                else begin job_on = 1; job_s = cyc + 1; end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit hit;
        rst = 1; en = 0; bv = 0; rdy = 0; dp = '0;
        cyc = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        // Reset state
        step();

        // T1/T2: continuous bits, fixed datapath result, consumer always ready
        en = 1; bv = 1; rdy = 1; dp = 16'h1234;
        repeat (1300) step();

        // T3: consumer stalls past the next due point
        rdy = 0; dp = 16'hBEEF;
        repeat (900) step();
        check("t3_overrun_set", overrun, 1'b1);
        rdy = 1;
        repeat (300) step();
        check("t3_overrun_sticky", overrun, 1'b1);

        // T4: half-rate input bits
        for (int i = 0; i < 2000; i++) begin
            bv = i[0];
            dp = 16'($urandom);
            step();
        end
        bv = 1;

        // T5: drop Enable while TapIdx is 100
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (job_on && cyc == job_s + 101) begin
                en = 0; hit = 1;
            end
            step();
            en = 1;
        end
        check("t5_abort_reached", hit, 1'b1);
        repeat (700) step();

        // T6: reset in the middle of CALC
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            if (job_on && cyc == job_s + 50) begin
                rst = 1; hit = 1;
            end
            step();
            rst = 0;
        end
        check("t6_reset_reached", hit, 1'b1);
        step();

        // Random traffic
        for (int i = 0; i < 20000; i++) begin
            en  = ($urandom_range(0, 799) != 0);
            bv  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) rdy = ~rdy;
            dp  = 16'($urandom);
            rst = ($urandom_range(0, 4999) == 0);
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
